// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the IF/MEM single-port SRAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 11;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W_DEF      = 16;
    localparam int STARVE_W       = 4;

    // Which port owns the SRAM read data returning next cycle.
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        IF_RESP = 2'd1,
        DM_RESP = 2'd2
    } resp_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; flags when it sits at its limit.
module arb_starve_ctr #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_at_max
);

    logic [W-1:0] r_cnt;

    assign o_at_max = (r_cnt == MAX);
    assign o_cnt    = r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between the fetch port and the load/store port,
// with data-port priority, a fetch starvation guard and read-response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_cen,
    output logic              sram_wen,
    input  logic [DATA_W-1:0] sram_q,
    output logic [CNT_W-1:0]  conflict_cnt
);

    resp_owner_e         r_owner;
    resp_owner_e         w_owner_nxt;
    logic                w_if_wins;
    logic                w_if_gnt;
    logic                w_dm_gnt;
    logic                w_starve_at_max;
    logic                w_starve_inc;
    logic [STARVE_W-1:0] w_unused_starve_cnt;
    logic                w_unused_conf_max;

    // Fetch wins when alone, or when it has been denied STARVE_MAX cycles in a row.
    assign w_if_wins = if_req & (~dm_req | w_starve_at_max);
    assign w_if_gnt  = ~rst & w_if_wins;
    assign w_dm_gnt  = ~rst & dm_req & ~w_if_wins;

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign stall_if  = if_req & ~w_if_gnt;
    assign stall_mem = dm_req & ~w_dm_gnt;

    assign sram_a   = rst ? '0 : (w_if_wins ? if_addr : dm_addr);
    assign sram_d   = rst ? '0 : dm_wdata;
    assign sram_cen = ~(w_if_gnt | w_dm_gnt);
    assign sram_wen = ~(w_dm_gnt & dm_we);

    assign w_starve_inc = if_req & ~w_if_gnt;

    arb_starve_ctr #(
        .W   (STARVE_W),
        .MAX (STARVE_W'(STARVE_MAX))
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_starve_inc),
        .i_clr    (~w_starve_inc),
        .o_cnt    (w_unused_starve_cnt),
        .o_at_max (w_starve_at_max)
    );

    arb_starve_ctr #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_conflict_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (if_req & dm_req),
        .i_clr    (1'b0),
        .o_cnt    (conflict_cnt),
        .o_at_max (w_unused_conf_max)
    );

    // A flushed fetch never claims the returning data; writes never produce a response.
    always_comb begin
        w_owner_nxt = NONE;
        if (w_if_gnt && !if_flush) begin
            w_owner_nxt = IF_RESP;
        end else if (w_dm_gnt && !dm_we) begin
            w_owner_nxt = DM_RESP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign if_rvalid = (r_owner == IF_RESP) & ~if_flush;
    assign dm_rvalid = (r_owner == DM_RESP);
    assign if_rdata  = sram_q;
    assign dm_rdata  = sram_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SMAX = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, stall_if, stall_mem;
    logic          sram_cen, sram_wen;
    logic [DW-1:0] if_rdata, dm_rdata, sram_d;
    logic [DW-1:0] sram_q = '0;
    logic [AW-1:0] sram_a;
    logic [CW-1:0] conflict_cnt;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .sram_a(sram_a), .sram_d(sram_d), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_q(sram_q), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: 1-cycle read latency, active-low enables.
    logic [DW-1:0] sram_mem [2**AW];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) sram_mem[sram_a] <= sram_d;
            else           sram_q <= sram_mem[sram_a];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: plain integers and a word array.
    logic [DW-1:0] ref_mem [2**AW];
    int            m_starve, m_conf;
    bit            m_pend_if, m_pend_dm;
    logic [DW-1:0] m_pend_if_data, m_pend_dm_data;
    bit            last_ig, last_dg;
    logic          obs_ig, obs_irv, obs_drv, obs_wen;
    logic [DW-1:0] obs_ird, obs_drd;

    task automatic model_reset();
        m_starve = 0; m_conf = 0; m_pend_if = 0; m_pend_dm = 0;
    endtask

    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic fl,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd);
        bit e_ig, e_dg, e_irv;
        @(posedge clk); #1;
        if_req = ir; if_addr = ia; if_flush = fl;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
        @(negedge clk);
        e_ig  = ir && (!dr || m_starve == SMAX);
        e_dg  = dr && !e_ig;
        e_irv = m_pend_if && !fl;
        obs_ig = if_gnt; obs_irv = if_rvalid; obs_drv = dm_rvalid; obs_wen = sram_wen;
        obs_ird = if_rdata; obs_drd = dm_rdata;
        check("if_gnt", if_gnt, e_ig);
        check("dm_gnt", dm_gnt, e_dg);
        check("stall_if", stall_if, ir && !e_ig);
        check("stall_mem", stall_mem, dr && !e_dg);
        check("sram_cen", sram_cen, !(e_ig || e_dg));
        check("sram_wen", sram_wen, !(e_dg && dw));
        if (e_ig) check("sram_a_if", sram_a, ia);
        if (e_dg) check("sram_a_dm", sram_a, da);
        if (e_dg && dw) check("sram_d", sram_d, dd);
        check("if_rvalid", if_rvalid, e_irv);
        check("dm_rvalid", dm_rvalid, m_pend_dm);
        if (e_irv)     check("if_rdata", if_rdata, m_pend_if_data);
        if (m_pend_dm) check("dm_rdata", dm_rdata, m_pend_dm_data);
        check("conflict_cnt", conflict_cnt, m_conf);
        // Advance the model to the state seen after the coming clock edge.
        if (e_ig || !ir) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (ir && dr && m_conf < CMAX) m_conf++;
        m_pend_if = e_ig && !fl;
        m_pend_dm = e_dg && !dw;
        m_pend_if_data = ref_mem[ia];
        m_pend_dm_data = ref_mem[da];
        if (e_dg && dw) ref_mem[da] = dd;
        last_ig = e_ig; last_dg = e_dg;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Asserts reset between edges with both ports requesting; outputs must drop at once.
    task automatic do_reset();
        @(negedge clk);
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; if_flush = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_dm_gnt", dm_gnt, 1'b0);
        check("rst_if_rvalid", if_rvalid, 1'b0);
        check("rst_dm_rvalid", dm_rvalid, 1'b0);
        check("rst_cen", sram_cen, 1'b1);
        check("rst_wen", sram_wen, 1'b1);
        check("rst_a", sram_a, 0);
        check("rst_d", sram_d, 0);
        check("rst_conflict", conflict_cnt, 0);
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [DW-1:0] fetch_data [3];
    logic ir, dr, dw, fl;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dd;

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        fetch_data[0] = 32'h13; fetch_data[1] = 32'h93; fetch_data[2] = 32'h113;
        for (int i = 0; i < 3; i++) begin
            sram_mem[i] = fetch_data[i];
            ref_mem[i]  = fetch_data[i];
        end
        model_reset();
        do_reset();

        // Fetch stream: back-to-back grants, data one cycle later without bubbles.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1'b1, AW'(i), 1'b0, 1'b0, 1'b0, '0, '0);
            else       idle();
            if (i < 3) check("fetch_gnt", obs_ig, 1'b1);
            if (i > 0) begin
                check("fetch_rvalid", obs_irv, 1'b1);
                check("fetch_rdata", obs_ird, fetch_data[i-1]);
            end
        end

        // Store then load of the same address returns the new data.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 11'd5, 32'hDEADBEEF);
        check("st_wen", obs_wen, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 11'd5, '0);
        check("ld_wen", obs_wen, 1'b1);
        check("st_no_rvalid", obs_drv, 1'b0);
        idle();
        check("ld_rvalid", obs_drv, 1'b1);
        check("ld_rdata", obs_drd, 32'hDEADBEEF);

        // Contention: dm wins four cycles, fetch wins the fifth, repeating.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 11'd20, 1'b0, 1'b1, 1'b0, 11'd21, '0);
            check("cont_pattern", obs_ig, (i % 5) == 4);
        end
        idle();
        check("cont_conflict10", conflict_cnt, 10);

        // Flush in the grant cycle, then flush in the return cycle.
        step(1'b1, 11'd8, 1'b1, 1'b0, 1'b0, '0, '0);
        idle();
        check("flush_grant", obs_irv, 1'b0);
        step(1'b1, 11'd8, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        check("flush_return", obs_irv, 1'b0);

        // Saturating conflict counter.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 11'd3, 1'b0, 1'b1, 1'b1, 11'd4, $urandom);
        idle();
        check("conflict_sat", conflict_cnt, CMAX);

        // Random traffic; requests held until granted, one mid-run reset.
        do_reset();
        ir = 0; dr = 0; dw = 0; ia = '0; da = '0; dd = '0;
        last_ig = 1; last_dg = 1;
        for (int n = 0; n < 400; n++) begin
            if (!ir || last_ig) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = AW'($urandom_range(0, 15));
            end
            if (!dr || last_dg) begin
                dr = ($urandom_range(0, 2) != 0);
                dw = $urandom_range(0, 1);
                da = AW'($urandom_range(0, 15));
                dd = $urandom;
            end
            fl = ($urandom_range(0, 7) == 0);
            step(ir, ia, fl, dr, dw, da, dd);
            if (n == 200) begin
                do_reset();
                ir = 0; dr = 0; last_ig = 1; last_dg = 1;
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous SRAM (1-cycle read latency, active-low write/chip enables) between the IF fetch port and the MEM-stage load/store port of the 5-stage pipeline.
- Grants at most one access per cycle; data port has priority.
- A starvation guard keeps fetch progressing.
- Exports per-port stall signals that the hazard logic ORs into its PC/IF_ID stall.
- Routes the registered read data back to the port that issued the read.

Parameters:
ADDR_W, 11, SRAM word-address width (2048 words).
DATA_W, 32, data width.
STARVE_MAX, 4, consecutive denied IF cycles after which IF wins the next contended cycle (1..15).
CNT_W, 16, width of saturating conflict counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset; asynchronous, active-high.
if_req  in  1  fetch read request; held stable until if_gnt.
if_addr  in  ADDR_W  fetch word address.
if_flush  in  1  branch taken; discard the IF read response returning next cycle.
if_gnt  out  1  fetch accepted this cycle (combinational).
if_rvalid  out  1  fetch data valid (registered).
if_rdata  out  DATA_W  fetch data.
dm_req  in  1  data access request; held stable until dm_gnt.
dm_we  in  1  1=write, 0=read.
dm_addr  in  ADDR_W  data word address.
dm_wdata  in  DATA_W  write data.
dm_gnt  out  1  data access accepted this cycle (combinational).
dm_rvalid  out  1  load data valid (registered; never for writes).
dm_rdata  out  DATA_W  load data.
stall_if  out  1  if_req & ~if_gnt.
stall_mem  out  1  dm_req & ~dm_gnt.
sram_a  out  ADDR_W  SRAM address.
sram_d  out  DATA_W  SRAM write data.
sram_cen  out  1  SRAM chip enable, active low.
sram_wen  out  1  SRAM write enable, active low.
sram_q  in  DATA_W  SRAM read data, valid the cycle after the address.
conflict_cnt  out  CNT_W  saturating count of cycles with both requests asserted.

Behaviour:
- Reset, asynchronous, while rst=1:
  - registered state cleared: resp_owner=NONE, starve_cnt=0, conflict_cnt=0, if_rvalid=0, dm_rvalid=0.
  - combinational outputs forced: if_gnt=dm_gnt=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
- Grant (combinational, one winner per cycle):
  - only dm_req: dm wins.
  - only if_req: if wins.
  - both: dm wins unless starve_cnt==STARVE_MAX, in which case if wins.
  - none: sram_cen=1, sram_wen=1.
- SRAM drive: winner's address drives sram_a and sram_cen=0. sram_wen=0 only when the dm winner has dm_we=1; sram_d=dm_wdata.
- Starve counter:
  - increments when if_req=1 and if_gnt=0, saturating at STARVE_MAX.
  - clears to 0 on if_gnt or when if_req=0.
- Response FSM, resp_owner register, states NONE / IF_RESP / DM_RESP:
  - next state = IF_RESP if the IF read is granted and if_flush=0.
  - next state = DM_RESP if a dm read is granted.
  - otherwise NONE.
  - Transitions occur every cycle; back-to-back grants are fully pipelined, no bubble.
- Read latency: 1 cycle.
  - if_rvalid=1 when resp_owner==IF_RESP and if_flush=0 in the current cycle; a flush in the return cycle also suppresses it.
  - dm_rvalid=1 when resp_owner==DM_RESP.
  - if_rdata=dm_rdata=sram_q; consumers qualify with rvalid.
- Writes: complete in the grant cycle; no rvalid.
- Same-address dm write and IF read in the same cycle cannot occur (single port). Back-to-back write then read of the same address returns the new data.
- conflict_cnt: increments on every cycle with if_req&dm_req; holds at all-ones.
- rst asserted mid-transaction: the pending response is dropped and no rvalid is produced after reset release. Requesters must reissue.

Decomposition:
- Package mem_arb_pkg: resp_owner_e enum {NONE, IF_RESP, DM_RESP}; default constants ADDR_W=11, DATA_W=32, STARVE_MAX=4.
- One sub-module, arb_starve_ctr: saturating counter with inc/clr inputs and an at_max output. The same module is reused for conflict_cnt with an all-ones limit.

Test Plan:
1. Reset: rst=1 mid-run -> all grants/rvalids=0, sram_cen=1, sram_wen=1, conflict_cnt=0 immediately, without waiting for a clock edge.
2. Fetch stream: if_req=1 at addrs 0,1,2 with SRAM preloaded 0x13,0x93,0x113 -> if_gnt=1 each cycle; if_rvalid=1 one cycle later with matching data, no bubbles.
3. Load/store: dm write addr 5 data 0xDEADBEEF, next cycle dm read addr 5 -> sram_wen=0 in the write cycle only; dm_rvalid=1 with 0xDEADBEEF the cycle after the read grant.
4. Contention: both requests held for 10 cycles with STARVE_MAX=4 -> dm granted 4 cycles, IF granted on cycle 5; pattern repeats; stall_if/stall_mem mirror the denials; conflict_cnt=10.
5. Flush: IF read granted at addr 8, if_flush=1 in the grant cycle -> no if_rvalid next cycle. Repeat with if_flush pulsed in the return cycle -> if_rvalid=0.
6. Saturation: CNT_W=4, 20 contended cycles -> conflict_cnt stops at 15.
